// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: state encodings, strobe
// idle level and the per-state strobe decode.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_TURN = 3'd4
  } state_t;

  // Inactive level of the active-low cs/oe/we strobes.
  localparam logic SRAM_STB_IDLE = 1'b1;

  // SRAM-side strobe bundle plus the data-bus drive enable.
  typedef struct packed {
    logic cs;
    logic oe;
    logic we;
    logic drv;
  } stb_t;

  localparam stb_t STB_RST = '{cs: SRAM_STB_IDLE, oe: SRAM_STB_IDLE,
                               we: SRAM_STB_IDLE, drv: 1'b0};

  // Strobe levels that must be visible on the pins while in state st.
  // drv and oe are never both active, so the bus is never fought over.
  function automatic stb_t stb_decode(state_t st);
    stb_t s;
    s = STB_RST;
    case (st)
      ST_WR: begin
        s.cs  = 1'b0;
        s.we  = 1'b0;
        s.drv = 1'b1;
      end
      ST_RD0, ST_RD1: begin
        s.cs = 1'b0;
        s.oe = 1'b0;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_ctrl_io_buf.sv
// DW-wide tri-state pad driver; keeps the inout out of the FSM logic.
module sram_io_buf #(
  parameter int DW = 8
) (
  input  logic          oe_i,
  input  logic [DW-1:0] d_i,
  inout  wire  [DW-1:0] pad
);

  // Drive the pad only when enabled, otherwise release it.
  assign pad = oe_i ? d_i : {DW{1'bz}};

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready request stream to async-strobe SRAM controller. All SRAM-side
// outputs are registered from the next state, so req_* never reaches the
// pins combinationally. Reads pass through TURN so the SRAM releases the
// bus before any following write drives it.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data
);

  state_t        state_q, state_d;
  stb_t          stb_d, stb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          accept;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: each access state lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_we ? ST_WR : ST_RD0;
      ST_WR:   state_d = ST_IDLE;
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    stb_d = stb_decode(state_d);
  end

  // Strobe and bus-drive registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) stb_q <= STB_RST;
    else       stb_q <= stb_d;
  end

  // Request capture; only on an accepted handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Read response: bus sampled at the end of RD1, pulse shown during TURN.
  // Reset drops the pending pulse so an aborted read never responds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_q == ST_RD1);
      if (state_q == ST_RD1) rsp_rdata <= sram_data;
    end
  end

  assign sram_cs   = stb_q.cs;
  assign sram_oe   = stb_q.oe;
  assign sram_we   = stb_q.we;
  assign sram_addr = addr_q;

  sram_io_buf #(.DW(DW)) u_io_buf (
    .oe_i (stb_q.drv),
    .d_i  (wdata_q),
    .pad  (sram_data)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed and randomized bench for sram_ctrl with a behavioural SRAM,
// a reference memory and a per-cycle bus contention monitor.
module tb_sram_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cs, sram_oe, sram_we;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] dout;

  sram_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural SRAM: write commits at the end of a cs/we-low cycle, the
  // output register loads while cs/oe are low and drives the bus then.
  always @(posedge clk_i) begin
    if (cyc == 0) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i) ^ 8'h3C;
    end else begin
      if (!sram_cs && !sram_we) mem[sram_addr] <= sram_data;
      if (!sram_cs && !sram_oe) dout <= mem[sram_addr];
    end
  end
  assign sram_data = (!sram_cs && !sram_oe) ? dout : {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Controller drives only with we low; SRAM drives only with oe low.
  always @(negedge clk_i) chk("bus_contention", 32'(!sram_we && !sram_oe), 32'd0);

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, return after the accept edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin step(); n++; end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    step();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int acc;
    issue(1'b1, a, d, acc);
    chk("wr_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b010);
    chk("wr_addr", 32'(sram_addr), 32'(a));
    chk("wr_data", 32'(sram_data), 32'(d));
    chk("wr_ready", 32'(req_ready), 32'd0);
    step();
    chk("wr_done_ready", 32'(req_ready), 32'd1);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    ref_mem[a] = d;
  endtask

  task automatic rd_op(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int acc;
    issue(1'b0, a, '0, acc);
    chk("rd0_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b001);
    chk("rd0_addr", 32'(sram_addr), 32'(a));
    chk("rd0_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("rd1_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b001);
    chk("rd1_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_latency", 32'(cyc - acc + 1), 32'd3);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    chk("turn_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b111);
    chk("turn_ready", 32'(req_ready), 32'd0);
    step();
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc1;
    logic          rwe;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    for (int i = 0; i < 2**AW; i++) ref_mem[i] = DW'(i) ^ 8'h3C;

    // Reset and idle quiet period.
    step(); step();
    rst_i = 1'b0;
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b111);
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
      step();
    end

    // Write then read back.
    wr_op(4'h3, 8'hA5);
    rd_op(4'h3, 8'hA5);

    // Back-to-back writes with req_valid held high.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h0; req_wdata = 8'h11;
    step();
    acc0 = cyc;
    req_addr = 4'hF; req_wdata = 8'hEE;
    chk("b2b_busy", 32'(req_ready), 32'd0);
    chk("b2b_wr0_addr", 32'(sram_addr), 32'h0);
    chk("b2b_wr0_data", 32'(sram_data), 32'h11);
    step();
    chk("b2b_ready", 32'(req_ready), 32'd1);
    step();
    acc1 = cyc;
    req_valid = 1'b0;
    chk("b2b_spacing", 32'(acc1 - acc0), 32'd2);
    chk("b2b_wr1_addr", 32'(sram_addr), 32'hF);
    chk("b2b_wr1_data", 32'(sram_data), 32'hEE);
    step();
    ref_mem[0] = 8'h11; ref_mem[15] = 8'hEE;
    rd_op(4'h0, 8'h11);
    rd_op(4'hF, 8'hEE);

    // Read immediately followed by a write to the same address.
    issue(1'b0, 4'h5, 8'h00, acc0);
    issue(1'b1, 4'h5, 8'h5A, acc1);
    chk("rw_turn_gap", 32'(acc1 - acc0), 32'd4);
    chk("rw_read_data", 32'(rsp_rdata), 32'h39);
    chk("rw_wr_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b010);
    chk("rw_wr_data", 32'(sram_data), 32'h5A);
    step();
    ref_mem[5] = 8'h5A;
    rd_op(4'h5, 8'h5A);

    // Reset during RD1 aborts the read with no response.
    issue(1'b0, 4'h7, 8'h00, acc0);
    step();
    rst_i = 1'b1;
    step();
    chk("abort_strobes", 32'({sram_cs, sram_oe, sram_we}), 32'b111);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    rst_i = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    step();
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_ready2", 32'(req_ready), 32'd1);

    // Random mix against the reference memory.
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) step();
      rwe = 1'($urandom_range(0, 1));
      ra  = AW'($urandom);
      rd  = DW'($urandom);
      if (rwe) wr_op(ra, rd);
      else     rd_op(ra, ref_mem[ra]);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous controller that turns a valid/ready request stream into the active-low cs/oe/we strobe protocol of the on-board SRAM (simulated by `sram_sim`), and returns read data on a one-cycle response strobe. It sits directly upstream of the SRAM in the BinaryNet memory path: weight/activation loaders issue word requests here, and this block owns the shared bidirectional data bus, including read-to-write turnaround.

## Interface
- `DW`, default 8: data word width; must equal the SRAM `DW`.
- `AW`, default 4: address width; must equal the SRAM `AW`.

- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_rdata` is valid.
- `rsp_rdata`  out  DW  read data; holds its value until the next read response.
- `sram_cs`  out  1  chip select, active low.
- `sram_oe`  out  1  output enable, active low.
- `sram_we`  out  1  write enable, active low.
- `sram_addr`  out  AW  SRAM address.
- `sram_data`  inout  DW  shared data bus; driven only in `WR`, otherwise `'z`.

## Operation
- States: `IDLE`, `WR`, `RD0`, `RD1`, `TURN`. All SRAM-side outputs are registered and decoded from the next state; no combinational path runs from `req_*` to `sram_*`.
- `req_ready = (state == IDLE)`. A request is accepted only on `req_valid && req_ready`. On acceptance, `req_addr`, `req_we` and `req_wdata` are latched. While `req_ready` is 0, `req_*` is ignored and nothing is captured.
- `IDLE`: `cs`, `oe` and `we` are all 1; the bus is released.
  - On an accepted write, go to `WR`.
  - On an accepted read, go to `RD0`.
- `WR` (1 cycle): `cs=0`, `we=0`, `oe=1`, `sram_addr` and the latched data are driven. The SRAM commits at the end of this cycle. Next state is `IDLE`.
- `RD0` (1 cycle): `cs=0`, `oe=0`, `we=1`, address driven, bus released. The SRAM loads its output register at the end of this cycle. Next state is `RD1`.
- `RD1` (1 cycle): strobes and address are held. At the end of the cycle, `sram_data` is sampled into `rsp_rdata` and `rsp_valid` is set. Next state is `TURN`.
- `TURN` (1 cycle): all strobes are 1, the bus is released, `rsp_valid=1`. Next state is `IDLE`. This cycle guarantees the SRAM has released the bus before any following write drives it.
- Reset values: state `IDLE`, `sram_cs`/`sram_oe`/`sram_we` = 1, `sram_addr` = 0, bus drive disabled, `rsp_valid` = 0, `rsp_rdata` = 0.
- Reset during any state: on the next cycle the strobes are 1, the bus is released, and no response is produced for the aborted read. A write is aborted if reset is asserted while its accept edge is pending; if reset arrives during `WR`, the write has already been committed at that edge.
- Addresses use the full `AW` range. There is no wrap or range check, so `2^AW-1` is a legal address.

## Timing
- Write: accepted at edge T → `WR` active in cycle T+1 → `req_ready` = 1 again in cycle T+2. Throughput is one write per 2 cycles.
- Read: accepted at edge T → `RD0` at T+1 → `RD1` at T+2 → `rsp_valid` = 1 at T+3 (`TURN`) → `req_ready` = 1 at T+4. Accept-to-response latency is 3 cycles; throughput is one read per 4 cycles.
- `rsp_valid` is high for exactly 1 cycle per read and never for writes. There is no response backpressure.
- Write-to-read and read-to-read need no extra gap beyond the states above. Read-to-write always passes through `TURN`.
- `sram_data` must never be driven by this block while `sram_oe` = 0.

## Structure
- The shared header `sram_defs.vh` holds:
  - state encodings (`ST_IDLE`…`ST_TURN`, 3-bit);
  - the strobe idle level (`SRAM_STB_IDLE` = 1'b1).
  Both this block and any future SRAM arbiter include it.
- One sub-module, `sram_io_buf`: a `DW`-wide tri-state driver with inputs `oe_i` and `d_i` and inout `pad`. It isolates the inout so the FSM stays purely synchronous.
- Total FSM, datapath registers and the buffer come to roughly 150–200 lines.

## Test plan
- After reset, with `req_valid` = 0 for 10 cycles: `req_ready` = 1, strobes = 1, `sram_data` = z, `rsp_valid` never asserted.
- Write 0xA5 to address 0x3, then read address 0x3:
  - `WR` shows `cs=0`, `we=0`, data 0xA5;
  - `rsp_valid` pulses exactly 3 cycles after the read is accepted;
  - `rsp_rdata` = 0xA5.
- Write 0x11 to address 0x0 and 0xEE to address 0xF back-to-back with `req_valid` held high, then read both:
  - each write is accepted only when `req_ready` = 1, with 2-cycle spacing;
  - the reads return 0x11 and 0xEE in order.
- Read address 0x5 immediately followed by write 0x5A to address 0x5:
  - `TURN` separates `oe=0` from `we=0`, and there is no cycle with both the controller and the SRAM driving;
  - the write is accepted 4 cycles after the read;
  - a subsequent read of 0x5 returns 0x5A.
- Assert `rst_i` in `RD1` of a read to address 0x7:
  - next cycle the strobes are 1 and `rsp_valid` = 0, with no response for that read;
  - `req_ready` = 1 in the first cycle after reset deasserts.
- Random mix of 500 reads and writes against a scoreboard model, with `req_valid` randomly deasserted: every read data matches the model, and a bus-contention checker reports none.
